// File: rtl/mesh_edge_io.sv
// -----------------------------------------------------------------------------
// mesh_edge_io
//   Edge adapter between one system AXI-Stream port and the row edges of a
//   ROWS-row PE mesh.
//   Ingress: system beats are scattered round-robin over the west-edge row
//   inputs (cfg_mode=0) or broadcast to every row (cfg_mode=1).
//   Egress : each east-edge row output lands in its own FIFO. The FIFOs are
//   merged round-robin into one registered output stream, and tdest carries
//   the source row.
//
//   Handshake rule for every stream: a beat transfers on a rising aclk edge
//   where tvalid and tready are both high. A source holds tdata stable while
//   tvalid is high and tready is low, and it does not withdraw tvalid.
//
// Parameters:
//   ROWS        number of mesh rows (>=2)
//   WIDTH       stream data width
//   FIFO_DEPTH  entries per egress row FIFO (power of two, >=2)
//   DEST_W      width of sys_out_tdest (derived from ROWS)
//
// Ports:
//   aclk, areset           clock; synchronous active-high reset
//   cfg_mode               0 = scatter, 1 = broadcast (quasi-static)
//   sys_in_*               system ingress stream (slave)
//   row_in_*               per-row streams to the mesh west edge (master)
//   row_out_*              per-row streams from the mesh east edge (slave)
//   sys_out_*              merged egress stream (master, registered)
//   stat_in_beats/out      beat counters, present only with MESH_EDGE_STATS_EN
//
// Optional feature macro: MESH_EDGE_STATS_EN (adds the two 32-bit counters).
// -----------------------------------------------------------------------------
module mesh_edge_io #(
   parameter int ROWS       = 4,
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int DEST_W     = $clog2(ROWS)
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cfg_mode,
   input  logic [WIDTH-1:0]        sys_in_tdata,
   input  logic                    sys_in_tvalid,
   output logic                    sys_in_tready,
   output logic [ROWS*WIDTH-1:0]   row_in_tdata,
   output logic [ROWS-1:0]         row_in_tvalid,
   input  logic [ROWS-1:0]         row_in_tready,
   input  logic [ROWS*WIDTH-1:0]   row_out_tdata,
   input  logic [ROWS-1:0]         row_out_tvalid,
   output logic [ROWS-1:0]         row_out_tready,
   output logic [WIDTH-1:0]        sys_out_tdata,
   output logic [DEST_W-1:0]       sys_out_tdest,
   output logic                    sys_out_tvalid,
   input  logic                    sys_out_tready
`ifdef MESH_EDGE_STATS_EN
   ,
   output logic [31:0]             stat_in_beats,
   output logic [31:0]             stat_out_beats
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // ---------------------------------------------------------------------------
   // Ingress
   // ---------------------------------------------------------------------------
   logic              mode_q;
   logic [DEST_W-1:0] ptr;
   logic [ROWS-1:0]   done;
   logic [ROWS-1:0]   done_nxt;
   logic              in_hs;

   // Data fans out to every lane; only the valids are steered.
   assign row_in_tdata = {ROWS{sys_in_tdata}};

   always_comb begin
      row_in_tvalid = '0;
      sys_in_tready = 1'b0;
      if (!areset) begin
         if (mode_q) begin
            row_in_tvalid = {ROWS{sys_in_tvalid}} & ~done;
            sys_in_tready = &(done | row_in_tready);
         end else begin
            row_in_tvalid[ptr] = sys_in_tvalid;
            sys_in_tready      = row_in_tready[ptr];
         end
      end
   end

   assign in_hs = sys_in_tvalid & sys_in_tready;

   always_comb begin
      done_nxt = '0;
      if (mode_q && !sys_in_tready)
         done_nxt = done | (row_in_tvalid & row_in_tready);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         ptr    <= '0;
         done   <= '0;
         mode_q <= cfg_mode;
      end else begin
         done <= done_nxt;
         // The mode only switches between beats, never with a broadcast
         // half-delivered (neither now nor after this edge).
         if (done == '0 && done_nxt == '0)
            mode_q <= cfg_mode;
         if (!mode_q && in_hs)
            ptr <= (ptr == DEST_W'(ROWS-1)) ? '0 : ptr + 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Egress row FIFOs (pointers carry one extra wrap bit)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] mem [ROWS][FIFO_DEPTH];
   logic [AW:0]      wp  [ROWS];
   logic [AW:0]      rp  [ROWS];
   logic [ROWS-1:0]  empty;
   logic [ROWS-1:0]  full;
   logic [ROWS-1:0]  push;
   logic [ROWS-1:0]  pop;

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         empty[r] = (wp[r] == rp[r]);
         full[r]  = (wp[r][AW] != rp[r][AW]) && (wp[r][AW-1:0] == rp[r][AW-1:0]);
      end
   end

   // Ready depends on registered pointers only, so a full FIFO stays not-ready
   // in the cycle it is popped: no path from sys_out_tready.
   assign row_out_tready = ~full & {ROWS{~areset}};
   assign push           = row_out_tvalid & row_out_tready;

   always_ff @(posedge aclk) begin
      for (int r = 0; r < ROWS; r++) begin
         if (push[r])
            mem[r][wp[r][AW-1:0]] <= row_out_tdata[r*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge aclk) begin
      for (int r = 0; r < ROWS; r++) begin
         if (areset) begin
            wp[r] <= '0;
            rp[r] <= '0;
         end else begin
            if (push[r]) wp[r] <= wp[r] + 1'b1;
            if (pop[r])  rp[r] <= rp[r] + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin merge into the output register
   // ---------------------------------------------------------------------------
   logic [DEST_W-1:0] last_grant;
   logic [DEST_W-1:0] winner;
   logic              any_ready;
   logic              load;

   // First non-empty row scanning upward from last_grant+1, with wrap.
   always_comb begin
      int idx;
      idx       = 0;
      winner    = '0;
      any_ready = 1'b0;
      for (int i = 1; i <= ROWS; i++) begin
         idx = (int'(last_grant) + i) % ROWS;
         if (!any_ready && !empty[idx]) begin
            any_ready = 1'b1;
            winner    = DEST_W'(idx);
         end
      end
   end

   assign load = (~sys_out_tvalid | sys_out_tready) & any_ready;

   always_comb begin
      pop = '0;
      if (load) pop[winner] = 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         sys_out_tvalid <= 1'b0;
         sys_out_tdata  <= '0;
         sys_out_tdest  <= '0;
         last_grant     <= DEST_W'(ROWS-1);
      end else if (~sys_out_tvalid | sys_out_tready) begin
         sys_out_tvalid <= any_ready;
         if (any_ready) begin
            sys_out_tdata <= mem[winner][rp[winner][AW-1:0]];
            sys_out_tdest <= winner;
            last_grant    <= winner;
         end
      end
   end

`ifdef MESH_EDGE_STATS_EN
   // ---------------------------------------------------------------------------
   // Beat counters (wrap naturally at 2^32)
   // ---------------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         stat_in_beats  <= '0;
         stat_out_beats <= '0;
      end else begin
         if (in_hs)                           stat_in_beats  <= stat_in_beats + 32'd1;
         if (sys_out_tvalid && sys_out_tready) stat_out_beats <= stat_out_beats + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mesh_edge_io.sv
// -----------------------------------------------------------------------------
// tb_mesh_edge_io
//   Directed bench for mesh_edge_io (ROWS=4, WIDTH=32, FIFO_DEPTH=4).
//   Expected beats are queued per row (ingress) and in arrival order (egress)
//   when stimulus is driven; a negedge monitor pops and compares on every
//   handshake. Inputs change 1 ns after the rising edge, direct checks run
//   2 ns after it.
// -----------------------------------------------------------------------------
module tb_mesh_edge_io;

   localparam int ROWS       = 4;
   localparam int WIDTH      = 32;
   localparam int FIFO_DEPTH = 4;
   localparam int DEST_W     = 2;

   logic                  aclk = 1'b0;
   logic                  areset;
   logic                  cfg_mode;
   logic [WIDTH-1:0]      sys_in_tdata;
   logic                  sys_in_tvalid;
   logic                  sys_in_tready;
   logic [ROWS*WIDTH-1:0] row_in_tdata;
   logic [ROWS-1:0]       row_in_tvalid;
   logic [ROWS-1:0]       row_in_tready;
   logic [ROWS*WIDTH-1:0] row_out_tdata;
   logic [ROWS-1:0]       row_out_tvalid;
   logic [ROWS-1:0]       row_out_tready;
   logic [WIDTH-1:0]      sys_out_tdata;
   logic [DEST_W-1:0]     sys_out_tdest;
   logic                  sys_out_tvalid;
   logic                  sys_out_tready;
`ifdef MESH_EDGE_STATS_EN
   logic [31:0]           stat_in_beats;
   logic [31:0]           stat_out_beats;
`endif

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0]        in_exp_q [ROWS][$];
   logic [DEST_W+WIDTH-1:0] exp_q[$];

   mesh_edge_io #(
      .ROWS(ROWS), .WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .DEST_W(DEST_W)
   ) dut (
      .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode),
      .sys_in_tdata(sys_in_tdata), .sys_in_tvalid(sys_in_tvalid),
      .sys_in_tready(sys_in_tready),
      .row_in_tdata(row_in_tdata), .row_in_tvalid(row_in_tvalid),
      .row_in_tready(row_in_tready),
      .row_out_tdata(row_out_tdata), .row_out_tvalid(row_out_tvalid),
      .row_out_tready(row_out_tready),
      .sys_out_tdata(sys_out_tdata), .sys_out_tdest(sys_out_tdest),
      .sys_out_tvalid(sys_out_tvalid), .sys_out_tready(sys_out_tready)
`ifdef MESH_EDGE_STATS_EN
      ,
      .stat_in_beats(stat_in_beats), .stat_out_beats(stat_out_beats)
`endif
   );

   // ---------------- clock / watchdog ----------------
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   // ---------------- check / driver helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic push_all_rows(input logic [WIDTH-1:0] d);
      for (int r = 0; r < ROWS; r++) in_exp_q[r].push_back(d);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge aclk) begin
      if (!areset) begin
         for (int r = 0; r < ROWS; r++) begin
            if (row_in_tvalid[r] && row_in_tready[r]) begin
               chk("in_unexpected_beat", in_exp_q[r].size() > 0, 1);
               if (in_exp_q[r].size() > 0)
                  chk("in_row_data", row_in_tdata[r*WIDTH +: WIDTH], in_exp_q[r].pop_front());
            end
         end
         if (sys_out_tvalid && sys_out_tready) begin
            chk("out_unexpected_beat", exp_q.size() > 0, 1);
            if (exp_q.size() > 0)
               chk("out_dest_data", {sys_out_tdest, sys_out_tdata}, exp_q.pop_front());
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int sent;
      int cnt;
      logic reg_full;
      logic pop_m;
      logic accepted;

      areset         = 1'b1;
      cfg_mode       = 1'b0;
      sys_in_tdata   = 32'h0;
      sys_in_tvalid  = 1'b1;
      row_in_tready  = 4'hF;
      row_out_tdata  = '0;
      row_out_tvalid = 4'h0;
      sys_out_tready = 1'b0;
      repeat (2) tick();
      #1;
      chk("rst_sys_in_tready", sys_in_tready, 0);
      chk("rst_row_in_tvalid", row_in_tvalid, 0);
      chk("rst_row_out_tready", row_out_tready, 0);
      chk("rst_sys_out_tvalid", sys_out_tvalid, 0);
      chk("rst_sys_out_tdata", sys_out_tdata, 0);
      chk("rst_sys_out_tdest", sys_out_tdest, 0);
`ifdef MESH_EDGE_STATS_EN
      chk("rst_stat_in", stat_in_beats, 0);
      chk("rst_stat_out", stat_out_beats, 0);
`endif
      sys_in_tvalid = 1'b0;
      tick();
      areset = 1'b0;
      tick();

      // Scatter, all rows ready: 0x10..0x17 to rows 0,1,2,3,0,1,2,3.
      for (int k = 0; k < 8; k++) begin
         sys_in_tdata  = 32'h10 + k;
         sys_in_tvalid = 1'b1;
         in_exp_q[k % ROWS].push_back(32'h10 + k);
         #1;
         chk("scatter_valid", row_in_tvalid, 4'b0001 << (k % ROWS));
         chk("scatter_ready", sys_in_tready, 1);
         tick();
      end

      // Two more beats move ptr to 2.
      for (int k = 0; k < 2; k++) begin
         sys_in_tdata = 32'h18 + k;
         in_exp_q[k].push_back(32'h18 + k);
         #1;
         chk("scatter_wrap_valid", row_in_tvalid, 4'b0001 << k);
         tick();
      end

      // Stall: row 2 not ready while ptr=2.
      row_in_tready = 4'b1011;
      sys_in_tdata  = 32'h20;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("stall_ready", sys_in_tready, 0);
         chk("stall_valid", row_in_tvalid, 4'b0100);
         tick();
      end
      row_in_tready = 4'hF;
      in_exp_q[2].push_back(32'h20);
      #1;
      chk("stall_release_ready", sys_in_tready, 1);
      tick();
      sys_in_tdata = 32'h21;
      in_exp_q[3].push_back(32'h21);
      #1;
      chk("after_stall_ptr3", row_in_tvalid, 4'b1000);
      tick();
      sys_in_tvalid = 1'b0;

      // Broadcast with staggered readies.
      cfg_mode = 1'b1;
      tick();
      sys_in_tdata  = 32'hAB;
      sys_in_tvalid = 1'b1;
      row_in_tready = 4'b1001;
      push_all_rows(32'hAB);
      #1;
      chk("bc_c0_valid", row_in_tvalid, 4'b1111);
      chk("bc_c0_ready", sys_in_tready, 0);
      tick();
      row_in_tready = 4'b0000;
      #1;
      chk("bc_c1_valid", row_in_tvalid, 4'b0110);
      chk("bc_c1_ready", sys_in_tready, 0);
      tick();
      row_in_tready = 4'b0110;
      #1;
      chk("bc_c2_valid", row_in_tvalid, 4'b0110);
      chk("bc_c2_ready", sys_in_tready, 1);
      tick();
      sys_in_tvalid = 1'b0;
      row_in_tready = 4'hF;
      tick();

      // Reset in the middle of a broadcast (rows 0,1 already served).
      sys_in_tdata  = 32'hCD;
      sys_in_tvalid = 1'b1;
      row_in_tready = 4'b0011;
      in_exp_q[0].push_back(32'hCD);
      in_exp_q[1].push_back(32'hCD);
      tick();
      row_in_tready = 4'b0000;
      #1;
      chk("mid_bc_partial_valid", row_in_tvalid, 4'b1100);
      areset = 1'b1;
      #1;
      chk("mid_rst_row_in_tvalid", row_in_tvalid, 0);
      chk("mid_rst_sys_in_tready", sys_in_tready, 0);
      chk("mid_rst_row_out_tready", row_out_tready, 0);
      tick();
      chk("mid_rst_sys_out_tvalid", sys_out_tvalid, 0);
      areset        = 1'b0;
      row_in_tready = 4'hF;
      sys_in_tdata  = 32'hCE;
      push_all_rows(32'hCE);
      #1;
      chk("post_rst_bc_valid", row_in_tvalid, 4'b1111);
      chk("post_rst_bc_ready", sys_in_tready, 1);
      tick();
      sys_in_tvalid = 1'b0;
      cfg_mode      = 1'b0;
      tick();

      // Egress arbitration: rows 0 and 2 push two beats each together.
      sys_out_tready = 1'b1;
      exp_q.push_back({2'd0, 32'hA0});
      exp_q.push_back({2'd2, 32'hC0});
      exp_q.push_back({2'd0, 32'hA1});
      exp_q.push_back({2'd2, 32'hC1});
      row_out_tvalid            = 4'b0101;
      row_out_tdata[0 +: WIDTH] = 32'hA0;
      row_out_tdata[64 +: WIDTH] = 32'hC0;
      #1;
      chk("arb_row_ready", row_out_tready, 4'hF);
      tick();
      row_out_tdata[0 +: WIDTH]  = 32'hA1;
      row_out_tdata[64 +: WIDTH] = 32'hC1;
      #1;
      chk("arb_no_valid_same_cycle", sys_out_tvalid, 0);
      tick();
      row_out_tvalid = 4'b0000;
      #1;
      chk("arb_first_valid", sys_out_tvalid, 1);
      chk("arb_first_dest", sys_out_tdest, 0);
      repeat (6) tick();
      chk("arb_drained", exp_q.size(), 0);

      // Backpressure: row 1 fills its FIFO behind a stalled output.
      sys_out_tready = 1'b0;
      sent     = 0;
      cnt      = 0;
      reg_full = 1'b0;
      for (int c = 0; c < 8; c++) begin
         row_out_tvalid              = 4'b0010;
         row_out_tdata[32 +: WIDTH]  = 32'h50 + sent;
         #1;
         chk("bp_row_ready", row_out_tready[1], cnt < FIFO_DEPTH);
         chk("bp_out_valid", sys_out_tvalid, reg_full);
         if (reg_full) begin
            chk("bp_hold_data", sys_out_tdata, 32'h50);
            chk("bp_hold_dest", sys_out_tdest, 1);
         end
         pop_m = !reg_full && (cnt > 0);
         if (cnt < FIFO_DEPTH) begin
            exp_q.push_back({2'd1, 32'h50 + sent});
            sent++;
            cnt++;
         end
         if (pop_m) begin
            cnt--;
            reg_full = 1'b1;
         end
         tick();
      end
      chk("bp_beats_accepted", sent, FIFO_DEPTH + 1);

      sys_out_tready = 1'b1;
      accepted = 1'b0;
      row_out_tdata[32 +: WIDTH] = 32'h50 + sent;
      for (int c = 0; c < 10; c++) begin
         if (!accepted) begin
            #1;
            if (row_out_tready[1]) begin
               exp_q.push_back({2'd1, 32'h50 + sent});
               accepted = 1'b1;
            end
            tick();
         end
      end
      chk("bp_last_accepted", accepted, 1);
      row_out_tvalid = 4'b0000;
      repeat (12) tick();

      chk("out_queue_empty", exp_q.size(), 0);
      for (int r = 0; r < ROWS; r++)
         chk("in_queue_empty", in_exp_q[r].size(), 0);
`ifdef MESH_EDGE_STATS_EN
      chk("stat_in_beats", stat_in_beats, 1);
      chk("stat_out_beats", stat_out_beats, 10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
